// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment reader: glyph patterns (active-low, bit order 6543210),
// FSM state type and the per-digit decode result.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    localparam logic [6:0] LOC_MAX     = 7'd31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_REPORT = 2'd2
    } seg7_state_t;

    typedef struct packed {
        logic [3:0] value;
        logic       legal;
    } seg7_digit_t;

    function automatic logic [6:0] pair_sum(input logic [3:0] tens, input logic [3:0] ones);
        return 7'(tens) * 7'd10 + 7'(ones);
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational decode of one active-low seven-segment pattern into a digit value,
// a blank flag and a legal-digit flag (blank is not a legal digit).
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0]  i_pattern,
    output seg7_digit_t o_digit,
    output logic        o_blank
);

    always_comb begin
        o_digit.value = 4'd0;
        o_digit.legal = 1'b1;
        o_blank       = 1'b0;
        case (i_pattern)
            GLYPH_0:     o_digit.value = 4'd0;
            GLYPH_1:     o_digit.value = 4'd1;
            GLYPH_2:     o_digit.value = 4'd2;
            GLYPH_3:     o_digit.value = 4'd3;
            GLYPH_4:     o_digit.value = 4'd4;
            GLYPH_5:     o_digit.value = 4'd5;
            GLYPH_6:     o_digit.value = 4'd6;
            GLYPH_7:     o_digit.value = 4'd7;
            GLYPH_8:     o_digit.value = 4'd8;
            GLYPH_9:     o_digit.value = 4'd9;
            GLYPH_BLANK: begin
                o_digit.legal = 1'b0;
                o_blank       = 1'b1;
            end
            default:     o_digit.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Reads a two-digit seven-segment display, debounces it and hands each new stable reading
// (0..31 or an error) to a ready/valid consumer. Define SEG7_READER_ERRCNT_EN to add err_count.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] HEX0,
    input  logic [6:0] HEX1,
    input  logic       out_ready,
    output logic [4:0] loc,
    output logic       out_valid,
    output logic       out_err
`ifdef SEG7_READER_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

    seg7_state_t r_state;
    logic [13:0] r_sample;
    logic [13:0] r_prev;
    logic [13:0] r_last;
    logic        r_last_vld;
    logic [7:0]  r_cnt;
    logic [4:0]  r_loc;
    logic        r_err;
    logic        r_valid;

    seg7_digit_t w_dig0;
    seg7_digit_t w_dig1;
    logic        w_blank0;
    logic        w_blank1;
    logic [3:0]  w_tens;
    logic [6:0]  w_sum;
    logic        w_tens_ok;
    logic        w_ones_ok;
    logic        w_pair_ok;
    logic        w_same;
    logic        w_changed;

    seg7_glyph_decode u_dec_ones (
        .i_pattern (r_sample[6:0]),
        .o_digit   (w_dig0),
        .o_blank   (w_blank0)
    );

    seg7_glyph_decode u_dec_tens (
        .i_pattern (r_sample[13:7]),
        .o_digit   (w_dig1),
        .o_blank   (w_blank1)
    );

    // A blank tens digit reads as zero; a displayed "0" on the tens digit is not a valid reading.
    always_comb begin
        w_tens    = w_blank1 ? 4'd0 : w_dig1.value;
        w_tens_ok = w_blank1 || (w_dig1.legal && (w_dig1.value >= 4'd1) && (w_dig1.value <= 4'd3));
        w_ones_ok = w_dig0.legal && !w_blank0;
        w_sum     = pair_sum(w_tens, w_dig0.value);
        w_pair_ok = w_tens_ok && w_ones_ok && (w_sum <= LOC_MAX);
        w_same    = (r_sample == r_prev);
        w_changed = !r_last_vld || (r_sample != r_last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_sample   <= {GLYPH_BLANK, GLYPH_BLANK};
            r_prev     <= {GLYPH_BLANK, GLYPH_BLANK};
            r_last     <= 14'd0;
            r_last_vld <= 1'b0;
            r_cnt      <= 8'd0;
            r_loc      <= 5'd0;
            r_err      <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_sample <= {HEX1, HEX0};
            r_prev   <= r_sample;
            case (r_state)
                ST_IDLE: begin
                    if (w_changed) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= 8'd1;
                    end
                end
                ST_SETTLE: begin
                    if (!w_same) begin
                        r_cnt <= 8'd1;
                    end else if (r_cnt >= STABLE_LIMIT) begin
                        r_state    <= ST_REPORT;
                        r_valid    <= 1'b1;
                        r_loc      <= w_pair_ok ? w_sum[4:0] : 5'd0;
                        r_err      <= !w_pair_ok;
                        r_last     <= r_sample;
                        r_last_vld <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_REPORT: begin
                    // Input changes are ignored here; IDLE re-evaluates the sample after the handshake.
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign loc       = r_loc;
    assign out_valid = r_valid;
    assign out_err   = r_err;

`ifdef SEG7_READER_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= 8'd0;
        end else if (r_valid && out_ready && r_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
